// File: rtl/camera_pose_ctrl_pkg.sv
// rtl/camera_pose_ctrl_pkg.sv - shared axis state type and default pose constants
package camera_pose_ctrl_pkg;

  typedef enum logic [1:0] {
    AX_IDLE = 2'd0,
    AX_SLOW = 2'd1,
    AX_FAST = 2'd2
  } axis_state_t;

  localparam int          DEF_N_AXES    = 3;
  localparam int          DEF_W         = 11;
  // Axis 0 occupies the least significant W bits.
  localparam logic [32:0] DEF_MAX_VALS  = {11'd355, 11'd1000, 11'd1000};
  localparam logic [32:0] DEF_INIT_VALS = '0;
  localparam logic [2:0]  DEF_WRAP_MASK = 3'b100;

endpackage

// File: rtl/camera_pose_ctrl_if.sv
// rtl/camera_pose_ctrl_if.sv - request, preset-load and pose output bundle
interface camera_pose_ctrl_if #(
  parameter int N_AXES = 3,
  parameter int W      = 11,
  parameter int AW     = (N_AXES > 1) ? $clog2(N_AXES) : 1
);
  logic [N_AXES-1:0]   inc;
  logic [N_AXES-1:0]   dec;
  logic                load_valid;
  logic [AW-1:0]       load_axis;
  logic [W-1:0]        load_value;
  logic                load_ready;
  logic [N_AXES*W-1:0] pos;
  logic [N_AXES-1:0]   fast;

  modport master (
    output inc, dec, load_valid, load_axis, load_value,
    input  load_ready, pos, fast
  );

  modport slave (
    input  inc, dec, load_valid, load_axis, load_value,
    output load_ready, pos, fast
  );
endinterface

// File: rtl/camera_pose_ctrl_axis.sv
// rtl/camera_pose_ctrl_axis.sv - one pose axis: IDLE/SLOW/FAST ramp, hold counter, clamp or wrap
module pose_axis
  import camera_pose_ctrl_pkg::*;
#(
  parameter int         W          = 11,
  parameter int         STEP_SLOW  = 5,
  parameter int         STEP_FAST  = 20,
  parameter int         HOLD_TICKS = 16,
  parameter logic [W-1:0] MAX_VAL  = '1,
  parameter logic [W-1:0] INIT_VAL = '0,
  parameter bit         WRAP       = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tick,
  input  logic         inc,
  input  logic         dec,
  input  logic         load_en,
  input  logic [W-1:0] load_value,
  output logic [W-1:0] pos,
  output logic         fast
);

  localparam int            HW        = $clog2(HOLD_TICKS) + 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
  localparam logic [W:0]    MAX_EXT   = {1'b0, MAX_VAL};
  localparam logic [W:0]    MODULUS   = MAX_EXT + 1'b1;
  localparam logic [W:0]    S_SLOW    = (W + 1)'(STEP_SLOW);
  localparam logic [W:0]    S_FAST    = (W + 1)'(STEP_FAST);

  axis_state_t   state, state_n;
  logic [HW-1:0] hold, hold_n;
  logic [W-1:0]  pos_n;
  logic          dir, dir_n;
  logic          req, same;

  // Extra bit keeps the overflow/underflow decision exact before clamping or wrapping.
  function automatic logic [W:0] stepped(input logic [W-1:0] p, input logic up,
                                         input logic [W:0] step);
    logic [W:0] pe, r;
    pe = {1'b0, p};
    if (up) begin
      r = pe + step;
      if (r > MAX_EXT) r = WRAP ? (r - MODULUS) : MAX_EXT;
    end else if (pe < step) begin
      r = WRAP ? (pe + MODULUS - step) : '0;
    end else begin
      r = pe - step;
    end
    return r;
  endfunction

  assign req  = inc ^ dec;
  assign same = req && (inc == dir);

  always_comb begin
    state_n = state;
    hold_n  = hold;
    pos_n   = pos;
    dir_n   = dir;
    if (load_en) begin
      pos_n   = (load_value > MAX_VAL) ? MAX_VAL : load_value;
      state_n = AX_IDLE;
      hold_n  = '0;
    end else if (tick) begin
      case (state)
        AX_IDLE: if (req) begin
          pos_n   = W'(stepped(pos, inc, S_SLOW));
          dir_n   = inc;
          hold_n  = '0;
          state_n = AX_SLOW;
        end
        AX_SLOW: if (same) begin
          pos_n  = W'(stepped(pos, dir, S_SLOW));
          hold_n = hold + HW'(1);
          if (hold_n == HOLD_LAST) state_n = AX_FAST;
        end else begin
          state_n = AX_IDLE;
        end
        AX_FAST: if (same) begin
          pos_n = W'(stepped(pos, dir, S_FAST));
        end else begin
          state_n = AX_IDLE;
        end
        default: state_n = AX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= AX_IDLE;
      hold  <= '0;
      pos   <= INIT_VAL;
      dir   <= 1'b1;
      fast  <= 1'b0;
    end else begin
      state <= state_n;
      hold  <= hold_n;
      pos   <= pos_n;
      dir   <= dir_n;
      fast  <= (state_n == AX_FAST);
    end
  end

endmodule

// File: rtl/camera_pose_ctrl.sv
// rtl/camera_pose_ctrl.sv - tick prescaler, preset-load handshake and per-axis pose controllers
module camera_pose_ctrl
  import camera_pose_ctrl_pkg::*;
#(
  parameter int                  N_AXES     = DEF_N_AXES,
  parameter int                  W          = DEF_W,
  parameter int                  TICK_DIV   = 250000,
  parameter int                  STEP_SLOW  = 5,
  parameter int                  STEP_FAST  = 20,
  parameter int                  HOLD_TICKS = 16,
  parameter logic [N_AXES*W-1:0] MAX_VALS   = DEF_MAX_VALS,
  parameter logic [N_AXES*W-1:0] INIT_VALS  = DEF_INIT_VALS,
  parameter logic [N_AXES-1:0]   WRAP_MASK  = DEF_WRAP_MASK
) (
  input  logic              clk,
  input  logic              reset,
  camera_pose_ctrl_if.slave bus
);

  localparam int AW = (N_AXES > 1) ? $clog2(N_AXES) : 1;
  localparam int CW = $clog2(TICK_DIV);

  logic [CW-1:0]       cnt;
  logic                tick;
  logic                load_fire;
  logic [N_AXES*W-1:0] pos_flat;
  logic [N_AXES-1:0]   fast_vec;

  assign tick = (cnt == CW'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt <= '0;
    else       cnt <= tick ? '0 : cnt + CW'(1);
  end

  // Loads are refused on tick cycles so an axis never sees a step and a load together.
  assign bus.load_ready = ~tick;
  assign load_fire      = bus.load_valid & ~tick;

  for (genvar g = 0; g < N_AXES; g++) begin : g_axis
    pose_axis #(
      .W         (W),
      .STEP_SLOW (STEP_SLOW),
      .STEP_FAST (STEP_FAST),
      .HOLD_TICKS(HOLD_TICKS),
      .MAX_VAL   (MAX_VALS[g*W +: W]),
      .INIT_VAL  (INIT_VALS[g*W +: W]),
      .WRAP      (WRAP_MASK[g])
    ) u_axis (
      .clk       (clk),
      .reset     (reset),
      .tick      (tick),
      .inc       (bus.inc[g]),
      .dec       (bus.dec[g]),
      .load_en   (load_fire && (bus.load_axis == AW'(g))),
      .load_value(bus.load_value),
      .pos       (pos_flat[g*W +: W]),
      .fast      (fast_vec[g])
    );
  end

  assign bus.pos  = pos_flat;
  assign bus.fast = fast_vec;

endmodule

// File: tb/tb_camera_pose_ctrl.sv
// tb/tb_camera_pose_ctrl.sv - directed self-checking bench for camera_pose_ctrl
module tb_camera_pose_ctrl;
  localparam int N = 3;
  localparam int W = 11;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  camera_pose_ctrl_if #(.N_AXES(N), .W(W)) bus ();

  // Axis 0 is the wrapping 0..355 axis; axes 1 and 2 saturate at 1000.
  camera_pose_ctrl #(
    .N_AXES(N), .W(W), .TICK_DIV(4), .STEP_SLOW(5), .STEP_FAST(20), .HOLD_TICKS(16),
    .MAX_VALS({11'd1000, 11'd1000, 11'd355}), .INIT_VALS('0), .WRAP_MASK(3'b001)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int axis_pos(int i);
    return int'(bus.pos[i*W +: W]);
  endfunction

  task automatic next_tick();
    bit seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (!bus.load_ready) begin seen = 1'b1; break; end
    end
    if (!seen) begin
      n_cmp++; n_err++;
      $display("FAIL tick_timeout: load_ready stayed high 12 cycles, required low every 4");
    end
    @(posedge clk); #1;
  endtask

  task automatic load(int axis, int value);
    bit ok = 1'b0;
    bus.load_axis  = 2'(axis);
    bus.load_value = 11'(value);
    bus.load_valid = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.load_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL load_timeout: load_ready never high, required high");
    end
    @(posedge clk); #1;
    bus.load_valid = 1'b0;
  endtask

  task automatic test_reset();
    int n = 0;
    bus.inc = '0; bus.dec = '0; bus.load_valid = 1'b0; bus.load_axis = '0; bus.load_value = '0;
    @(posedge clk); #1;
    n_cmp++; if (bus.pos !== '0) begin n_err++; $display("FAIL reset_pos: got %0h, required 0", bus.pos); end
    n_cmp++; if (bus.fast !== '0) begin n_err++; $display("FAIL reset_fast: got %b, required 000", bus.fast); end
    n_cmp++; if (bus.load_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b, required 1", bus.load_ready); end
    @(negedge clk); reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1; n++;
      if (!bus.load_ready) break;
    end
    n_cmp++; if (n != 3) begin n_err++; $display("FAIL first_tick: tick after %0d edges, required 3", n); end
    @(posedge clk); #1;
    n_cmp++; if (bus.load_ready !== 1'b1) begin n_err++; $display("FAIL ready_one_cycle: got %b, required 1", bus.load_ready); end
  endtask

  task automatic test_slow();
    bus.inc = 3'b010;
    for (int t = 1; t <= 3; t++) begin
      next_tick();
      n_cmp++; if (axis_pos(1) != 5*t) begin n_err++; $display("FAIL slow_pos t=%0d: got %0d, required %0d", t, axis_pos(1), 5*t); end
      n_cmp++; if (bus.fast[1] !== 1'b0) begin n_err++; $display("FAIL slow_fast t=%0d: got %b, required 0", t, bus.fast[1]); end
    end
    n_cmp++; if (axis_pos(0) != 0 || axis_pos(2) != 0) begin n_err++; $display("FAIL slow_indep: got %0d/%0d, required 0/0", axis_pos(0), axis_pos(2)); end
    bus.inc = '0;
    next_tick();
    n_cmp++; if (axis_pos(1) != 15) begin n_err++; $display("FAIL slow_release: got %0d, required 15", axis_pos(1)); end
  endtask

  task automatic test_fast();
    int ep;
    load(1, 0);
    bus.inc = 3'b010;
    for (int t = 1; t <= 20; t++) begin
      next_tick();
      ep = (t <= 16) ? 5*t : 80 + 20*(t - 16);
      n_cmp++; if (axis_pos(1) != ep) begin n_err++; $display("FAIL fast_pos t=%0d: got %0d, required %0d", t, axis_pos(1), ep); end
      n_cmp++; if (bus.fast[1] !== (t >= 16)) begin n_err++; $display("FAIL fast_flag t=%0d: got %b, required %b", t, bus.fast[1], t >= 16); end
    end
    bus.inc = '0;
    next_tick();
    n_cmp++; if (bus.fast[1] !== 1'b0 || axis_pos(1) != 160) begin n_err++; $display("FAIL fast_release: got %0d/%b, required 160/0", axis_pos(1), bus.fast[1]); end
  endtask

  task automatic test_saturate();
    load(1, 995);
    bus.inc = 3'b010;
    for (int t = 1; t <= 2; t++) begin
      next_tick();
      n_cmp++; if (axis_pos(1) != 1000) begin n_err++; $display("FAIL sat_hi t=%0d: got %0d, required 1000", t, axis_pos(1)); end
    end
    bus.inc = '0;
    next_tick();
    load(1, 3);
    bus.dec = 3'b010;
    for (int t = 1; t <= 2; t++) begin
      next_tick();
      n_cmp++; if (axis_pos(1) != 0) begin n_err++; $display("FAIL sat_lo t=%0d: got %0d, required 0", t, axis_pos(1)); end
    end
    bus.dec = '0;
    next_tick();
  endtask

  task automatic test_wrap();
    load(0, 352);
    bus.inc = 3'b001;
    next_tick();
    n_cmp++; if (axis_pos(0) != 1) begin n_err++; $display("FAIL wrap_up: got %0d, required 1", axis_pos(0)); end
    bus.inc = '0;
    next_tick();
    load(0, 2);
    bus.dec = 3'b001;
    next_tick();
    n_cmp++; if (axis_pos(0) != 353) begin n_err++; $display("FAIL wrap_down: got %0d, required 353", axis_pos(0)); end
    bus.dec = '0;
    next_tick();
  endtask

  task automatic test_conflict();
    load(0, 100);
    bus.inc = 3'b001; bus.dec = 3'b001;
    for (int t = 1; t <= 2; t++) begin
      next_tick();
      n_cmp++; if (axis_pos(0) != 100 || bus.fast[0] !== 1'b0) begin n_err++; $display("FAIL both_held t=%0d: got %0d/%b, required 100/0", t, axis_pos(0), bus.fast[0]); end
    end
    bus.dec = '0;
    next_tick();
    n_cmp++; if (axis_pos(0) != 105) begin n_err++; $display("FAIL both_then_inc: got %0d, required 105", axis_pos(0)); end
    bus.inc = '0;
    next_tick();
    load(1, 0);
    bus.inc = 3'b010;
    repeat (17) next_tick();
    n_cmp++; if (axis_pos(1) != 100 || bus.fast[1] !== 1'b1) begin n_err++; $display("FAIL rev_setup: got %0d/%b, required 100/1", axis_pos(1), bus.fast[1]); end
    bus.inc = '0; bus.dec = 3'b010;
    next_tick();
    n_cmp++; if (axis_pos(1) != 100 || bus.fast[1] !== 1'b0) begin n_err++; $display("FAIL rev_idle: got %0d/%b, required 100/0", axis_pos(1), bus.fast[1]); end
    next_tick();
    n_cmp++; if (axis_pos(1) != 95 || bus.fast[1] !== 1'b0) begin n_err++; $display("FAIL rev_slow: got %0d/%b, required 95/0", axis_pos(1), bus.fast[1]); end
    bus.dec = '0;
    next_tick();
  endtask

  task automatic test_load();
    bit seen = 1'b0;
    bus.inc = 3'b100;
    repeat (16) next_tick();
    n_cmp++; if (axis_pos(2) != 80 || bus.fast[2] !== 1'b1) begin n_err++; $display("FAIL load_setup: got %0d/%b, required 80/1", axis_pos(2), bus.fast[2]); end
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (!bus.load_ready) begin seen = 1'b1; break; end
    end
    if (!seen) begin n_cmp++; n_err++; $display("FAIL load_tick_timeout: no tick cycle seen"); end
    bus.load_axis = 2'd2; bus.load_value = 11'd2000; bus.load_valid = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (axis_pos(2) != 100 || bus.fast[2] !== 1'b1) begin n_err++; $display("FAIL load_held: got %0d/%b, required 100/1", axis_pos(2), bus.fast[2]); end
    n_cmp++; if (bus.load_ready !== 1'b1) begin n_err++; $display("FAIL load_ready_after_tick: got %b, required 1", bus.load_ready); end
    @(posedge clk); #1;
    n_cmp++; if (axis_pos(2) != 1000 || bus.fast[2] !== 1'b0) begin n_err++; $display("FAIL load_clamp: got %0d/%b, required 1000/0", axis_pos(2), bus.fast[2]); end
    bus.load_valid = 1'b0; bus.inc = '0;
    next_tick();
    n_cmp++; if (axis_pos(2) != 1000 || bus.fast[2] !== 1'b0) begin n_err++; $display("FAIL load_idle: got %0d/%b, required 1000/0", axis_pos(2), bus.fast[2]); end
    load(3, 7);
    n_cmp++; if (bus.pos !== {11'd1000, 11'd95, 11'd105}) begin n_err++; $display("FAIL load_bad_axis: got %0h, required %0h", bus.pos, {11'd1000, 11'd95, 11'd105}); end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    load(1, 0);
    bus.inc = 3'b010;
    repeat (5) next_tick();
    n_cmp++; if (axis_pos(1) != 25) begin n_err++; $display("FAIL mid_setup: got %0d, required 25", axis_pos(1)); end
    bus.load_axis = 2'd0; bus.load_value = 11'd50; bus.load_valid = 1'b1;
    #2; reset = 1'b1; #1;
    n_cmp++; if (bus.pos !== '0 || bus.fast !== '0) begin n_err++; $display("FAIL mid_reset: got %0h/%b, required 0/000", bus.pos, bus.fast); end
    n_cmp++; if (bus.load_ready !== 1'b1) begin n_err++; $display("FAIL mid_reset_ready: got %b, required 1", bus.load_ready); end
    bus.load_valid = 1'b0; bus.inc = '0;
    @(negedge clk); reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1; n++;
      if (!bus.load_ready) break;
    end
    n_cmp++; if (n != 3) begin n_err++; $display("FAIL mid_first_tick: tick after %0d edges, required 3", n); end
    bus.inc = 3'b010;
    next_tick();
    n_cmp++; if (axis_pos(1) != 5 || bus.fast[1] !== 1'b0 || axis_pos(0) != 0) begin n_err++; $display("FAIL mid_restart: got %0d/%b/%0d, required 5/0/0", axis_pos(1), bus.fast[1], axis_pos(0)); end
    bus.inc = '0;
  endtask

  initial begin
    test_reset();
    test_slow();
    test_fast();
    test_saturate();
    test_wrap();
    test_conflict();
    test_load();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
